// File: rtl/pipe_hazard_scoreboard.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// A PIPE_DEPTH-slot shift scoreboard tracks in-flight register writers
// (slot 1 = EX ... slot PIPE_DEPTH = WB). The block drives the forwarding
// selects, the load-use stall and the taken-branch flushes, and keeps
// saturating stall and flush counters.
// Optional feature: define FWD_EN to enable forwarding. Without it the
// selects are tied to 0 and any writer in slots 1..PIPE_DEPTH-1 stalls.
module pipe_hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned PIPE_DEPTH   = 3,
    parameter int unsigned LOAD_STAGE   = 2,
    parameter int unsigned BRANCH_STAGE = 2,
    parameter int unsigned CNT_W        = 32,
    localparam int unsigned FSEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  br_taken,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [FSEL_W-1:0]     fwd_a,
    output logic [FSEL_W-1:0]     fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [PIPE_DEPTH:1]                 v_q, v_d;
    logic [PIPE_DEPTH:1]                 wr_q, wr_d;
    logic [PIPE_DEPTH:1]                 ld_q, ld_d;
    logic [PIPE_DEPTH:1][REG_ADDR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]                    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]                    flush_cnt_q, flush_cnt_d;

    logic [FSEL_W-1:0] sel_a, sel_b;
    logic              rdy_a, rdy_b;
    logic              haz_a, haz_b;
    logic [FSEL_W-1:0] fwd_a_c, fwd_b_c;

    // Youngest matching writer per source operand and whether its result exists yet.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        // Walk oldest to youngest so the lowest matching slot is the one left standing.
        for (int unsigned k = PIPE_DEPTH; k >= 1; k--) begin
            if (v_q[k] && wr_q[k] && (rd_q[k] == id_rs) && (id_rs != '0)) begin
                sel_a = FSEL_W'(k);
                rdy_a = !ld_q[k] || (k >= LOAD_STAGE) || (k == PIPE_DEPTH);
            end
            if (v_q[k] && wr_q[k] && (rd_q[k] == id_rt) && (id_rt != '0)) begin
                sel_b = FSEL_W'(k);
                rdy_b = !ld_q[k] || (k >= LOAD_STAGE) || (k == PIPE_DEPTH);
            end
        end
    end

`ifdef FWD_EN
    // Stall only on a not-yet-available load result; otherwise bypass from the slot.
    always_comb begin
        haz_a   = id_use_rs && (sel_a != '0) && !rdy_a;
        haz_b   = id_use_rt && (sel_b != '0) && !rdy_b;
        fwd_a_c = '0;
        fwd_b_c = '0;
        if (id_use_rs && (sel_a != '0) && rdy_a && (sel_a < FSEL_W'(PIPE_DEPTH))) fwd_a_c = sel_a;
        if (id_use_rt && (sel_b != '0) && rdy_b && (sel_b < FSEL_W'(PIPE_DEPTH))) fwd_b_c = sel_b;
    end
`else
    logic unused_rdy;
    assign unused_rdy = rdy_a ^ rdy_b;

    // No bypass network: wait until the writer sits in WB (write-through regfile).
    always_comb begin
        haz_a   = id_use_rs && (sel_a != '0) && (sel_a < FSEL_W'(PIPE_DEPTH));
        haz_b   = id_use_rt && (sel_b != '0) && (sel_b < FSEL_W'(PIPE_DEPTH));
        fwd_a_c = '0;
        fwd_b_c = '0;
    end
`endif

    // Outputs; held at 0 while reset is asserted. A taken branch overrides any stall.
    always_comb begin
        stall       = Reset && id_valid && !br_taken && (haz_a || haz_b);
        flush_if_id = Reset && br_taken;
        flush_id_ex = Reset && br_taken;
        fwd_a       = Reset ? fwd_a_c : '0;
        fwd_b       = Reset ? fwd_b_c : '0;
        stall_cnt   = stall_cnt_q;
        flush_cnt   = flush_cnt_q;
    end

    // Scoreboard shift and saturating counter next state.
    always_comb begin
        v_d[1]  = id_valid && !stall && !br_taken;
        rd_d[1] = id_rd;
        wr_d[1] = id_reg_write;
        ld_d[1] = id_is_load;
        for (int unsigned k = 2; k <= PIPE_DEPTH; k++) begin
            // Instructions younger than the resolving branch are squashed as they advance.
            v_d[k]  = v_q[k-1] && !(br_taken && ((k - 1) < BRANCH_STAGE));
            rd_d[k] = rd_q[k-1];
            wr_d[k] = wr_q[k-1];
            ld_d[k] = ld_q[k-1];
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_if_id && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // State registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            v_q         <= '0;
            wr_q        <= '0;
            ld_q        <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            wr_q        <= wr_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
